pyrreconstruct_top_div_seq_32s_9ns_24s: RTL and testbench

PYRRECONSTRUCT_TOP_DIV_SEQ_32S_9NS_24S -- requirements
Module: pyrreconstruct_top_div_seq_32s_9ns_24s

---
 rtl/pyrreconstruct_top_div_seq_32s_9ns_24s.sv | 174 +++++++++++++++++
 tb/tb_pyrreconstruct_top_div_seq_32s_9ns_24s.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pyrreconstruct_top_div_seq_32s_9ns_24s.sv
// -----------------------------------------------------------------------------
// pyrreconstruct_top_div_seq_32s_9ns_24s
//
// Sequential signed/unsigned divider. It divides a signed 32-bit dividend by an
// unsigned 9-bit divisor with a restoring shift-subtract loop. The loop
// produces one quotient bit per clock-enabled cycle.
//
// Ports
//   ap_clk   : clock, all state changes on the rising edge
//   ap_rst   : asynchronous active-high reset, forces IDLE and clears outputs
//   ce       : clock enable; when low, all state and outputs are held
//   start    : begin a division (accepted only in IDLE)
//   din0     : signed dividend (32 bits)
//   din1     : unsigned divisor (9 bits)
//   dout     : signed quotient (24 bits), truncated toward zero
//   rem      : signed remainder (10 bits), same sign as the dividend
//   busy     : high whenever the FSM is not in IDLE
//   done     : one-cycle completion pulse
//   div_zero : the current result came from a zero divisor
//   ovf      : the true quotient does not fit in 24 signed bits
//
// Timing: a start accepted at edge k raises done at edge k+33. A zero divisor
// raises done at edge k+1. Cycles with ce low add to this latency.
//
// Build option
//   PYR_DIV_SAT_EN : when defined, an overflowing quotient saturates to
//                    0x7FFFFF or 0x800000. When undefined, dout carries the
//                    low 24 bits of the true quotient. ovf is flagged in
//                    both builds.
// -----------------------------------------------------------------------------
module pyrreconstruct_top_div_seq_32s_9ns_24s #(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          din0_WIDTH = 32,
  parameter int          din1_WIDTH = 9,
  parameter int          dout_WIDTH = 24
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [9:0]            rem,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic                  ovf
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // ID is an instance tag only.
  logic unused_id;
  assign unused_id = ^ID;

  state_t      state_reg;
  logic [5:0]  cnt_reg;       // counts iterations 0..32
  logic        a_neg_reg;     // sign of the latched dividend
  logic [8:0]  d_reg;         // latched divisor
  logic [31:0] q_reg;         // dividend magnitude shifting out, quotient shifting in
  logic [8:0]  r_reg;         // partial remainder, always < divisor
  logic [23:0] dout_reg;
  logic [9:0]  rem_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        div_zero_reg;
  logic        ovf_reg;

  // Magnitude of the incoming dividend. For -2^31 this gives 0x8000_0000,
  // which is still correct when read as an unsigned number.
  logic [31:0] abs_din0;
  assign abs_din0 = din0[31] ? (~din0 + 32'd1) : din0;

  // One restoring step. The divisor is at most 511 and the remainder is always
  // smaller than the divisor, so the trial value fits in 10 bits. When the
  // divisor fits, the 9-bit difference is exact.
  logic [9:0]  trial;
  logic        trial_ge;
  logic [8:0]  r_next;
  logic [31:0] q_next;
  assign trial    = {r_reg, q_reg[31]};
  assign trial_ge = (trial >= {1'b0, d_reg});
  assign r_next   = trial_ge ? (trial[8:0] - d_reg) : trial[8:0];
  assign q_next   = {q_reg[30:0], trial_ge};

  // Sign correction is done on 33 bits, so a quotient magnitude of 2^31 cannot
  // wrap before the range check.
  logic [32:0] quo_s;
  logic        quo_ovf;
  logic [9:0]  rem_s;
  logic [23:0] sat_val;
  logic [23:0] dout_fin;
  assign quo_s   = a_neg_reg ? (33'd0 - {1'b0, q_reg}) : {1'b0, q_reg};
  assign quo_ovf = ($signed(quo_s) > 33'sd8388607) || ($signed(quo_s) < -33'sd8388608);
  assign rem_s   = a_neg_reg ? (10'd0 - {1'b0, r_reg}) : {1'b0, r_reg};
  assign sat_val = a_neg_reg ? 24'h800000 : 24'h7FFFFF;

`ifdef PYR_DIV_SAT_EN
  assign dout_fin = quo_ovf ? sat_val : quo_s[23:0];
`else
  assign dout_fin = quo_s[23:0];
`endif

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 6'd0;
      a_neg_reg    <= 1'b0;
      d_reg        <= 9'd0;
      q_reg        <= 32'd0;
      r_reg        <= 9'd0;
      dout_reg     <= 24'd0;
      rem_reg      <= 10'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else if (ce) begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_neg_reg <= din0[31];
            d_reg     <= din1;
            q_reg     <= abs_din0;
            r_reg     <= 9'd0;
            cnt_reg   <= 6'd0;
            busy_reg  <= 1'b1;
            state_reg <= CALC;
          end
        end
        CALC: begin
          if (d_reg == 9'd0) begin
            // Zero divisor: skip the iterations and report saturation.
            dout_reg     <= sat_val;
            rem_reg      <= 10'd0;
            div_zero_reg <= 1'b1;
            ovf_reg      <= 1'b0;
            done_reg     <= 1'b1;
            state_reg    <= DONE;
          end else if (cnt_reg == 6'd32) begin
            dout_reg     <= dout_fin;
            rem_reg      <= rem_s;
            div_zero_reg <= 1'b0;
            ovf_reg      <= quo_ovf;
            done_reg     <= 1'b1;
            state_reg    <= DONE;
          end else begin
            q_reg   <= q_next;
            r_reg   <= r_next;
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign dout     = dout_reg;
  assign rem      = rem_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_pyrreconstruct_top_div_seq_32s_9ns_24s.sv
// -----------------------------------------------------------------------------
// Directed testbench for pyrreconstruct_top_div_seq_32s_9ns_24s.
// Inputs are driven on the falling edge and outputs are sampled on the falling
// edge. Latency is the number of rising edges after the start edge k.
// -----------------------------------------------------------------------------
module tb_pyrreconstruct_top_div_seq_32s_9ns_24s;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ce     = 1'b0;
  logic        start  = 1'b0;
  logic [31:0] din0   = 32'd0;
  logic [8:0]  din1   = 9'd0;
  logic [23:0] dout;
  logic [9:0]  rem;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  pyrreconstruct_top_div_seq_32s_9ns_24s dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ce       (ce),
    .start    (start),
    .din0     (din0),
    .din1     (din1),
    .dout     (dout),
    .rem      (rem),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .ovf      (ovf)
  );

  always #5 ap_clk = ~ap_clk;

  // Present operands with start high across exactly one rising edge (edge k).
  // Returns at the falling edge just after edge k.
  task automatic do_start(input logic [31:0] a, input logic [8:0] b);
    @(negedge ap_clk);
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
  endtask

  // Advance falling edges until done is seen. Returns the edge offset from k,
  // or -1 if the cycle budget runs out.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 120) begin
      @(negedge ap_clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge ap_clk);
    n_checks++;
    if ({dout, rem, busy, done, div_zero, ovf} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dout=%h rem=%h busy=%b done=%b dz=%b ovf=%b, required all 0",
               dout, rem, busy, done, div_zero, ovf);
    end
    ap_rst = 1'b0;
    ce     = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] va [8] = '{32'd1000, -32'sd1000, 32'h80000000, -32'sd7,
                            32'd100000, 32'd0, 32'd8388607, -32'sd8388608};
    logic [8:0]  vb [8] = '{9'd7, 9'd7, 9'd256, 9'd2, 9'd511, 9'd9, 9'd1, 9'd1};
    logic [23:0] vq [8] = '{24'h00008E, 24'hFFFF72, 24'h800000, 24'hFFFFFD,
                            24'h0000C3, 24'h000000, 24'h7FFFFF, 24'h800000};
    logic [9:0]  vr [8] = '{10'd6, 10'h3FA, 10'd0, 10'h3FF, 10'd355, 10'd0, 10'd0, 10'd0};
    int lat;
    for (int i = 0; i < 8; i++) begin
      do_start(va[i], vb[i]);
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_busy[%0d]: got busy=%b, required 1", i, busy);
      end
      wait_done(0, lat);
      $display("div a=%0d b=%0d -> dout=%h rem=%h ovf=%b dz=%b lat=%0d",
               $signed(va[i]), vb[i], dout, rem, ovf, div_zero, lat);
      n_checks++;
      if (lat != 33) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: got %0d, required 33", i, lat);
      end
      n_checks++;
      if (dout !== vq[i] || rem !== vr[i]) begin
        n_fail++;
        $display("FAIL basic_result[%0d]: got dout=%h rem=%h, required dout=%h rem=%h",
                 i, dout, rem, vq[i], vr[i]);
      end
      n_checks++;
      if (ovf !== 1'b0 || div_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_flags[%0d]: got ovf=%b dz=%b, required 0 0", i, ovf, div_zero);
      end
      @(negedge ap_clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dout !== vq[i]) begin
        n_fail++;
        $display("FAIL basic_after_done[%0d]: got done=%b busy=%b dout=%h, required 0 0 %h",
                 i, done, busy, dout, vq[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] va [3] = '{-32'sd5, 32'd5, 32'd0};
    logic [23:0] vq [3] = '{24'h800000, 24'h7FFFFF, 24'h7FFFFF};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_start(va[i], 9'd0);
      wait_done(0, lat);
      $display("div a=%0d b=0 -> dout=%h rem=%h dz=%b lat=%0d", $signed(va[i]), dout, rem, div_zero, lat);
      n_checks++;
      if (lat != 1) begin
        n_fail++;
        $display("FAIL divzero_latency[%0d]: got %0d, required 1", i, lat);
      end
      n_checks++;
      if (dout !== vq[i] || rem !== 10'd0 || div_zero !== 1'b1 || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL divzero_result[%0d]: got dout=%h rem=%h dz=%b ovf=%b, required %h 000 1 0",
                 i, dout, rem, div_zero, ovf, vq[i]);
      end
      @(negedge ap_clk);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] va [3] = '{32'h7FFFFFFF, 32'd8388608, -32'sd8388609};
`ifdef PYR_DIV_SAT_EN
    logic [23:0] vq [3] = '{24'h7FFFFF, 24'h7FFFFF, 24'h800000};
`else
    logic [23:0] vq [3] = '{24'hFFFFFF, 24'h800000, 24'h7FFFFF};
`endif
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_start(va[i], 9'd1);
      wait_done(0, lat);
      $display("div a=%0d b=1 -> dout=%h rem=%h ovf=%b lat=%0d", $signed(va[i]), dout, rem, ovf, lat);
      n_checks++;
      if (lat != 33) begin
        n_fail++;
        $display("FAIL ovf_latency[%0d]: got %0d, required 33", i, lat);
      end
      n_checks++;
      if (ovf !== 1'b1 || div_zero !== 1'b0 || dout !== vq[i] || rem !== 10'd0) begin
        n_fail++;
        $display("FAIL ovf_result[%0d]: got ovf=%b dz=%b dout=%h rem=%h, required 1 0 %h 000",
                 i, ovf, div_zero, dout, rem, vq[i]);
      end
      @(negedge ap_clk);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int extra_done;
    do_start(32'd1000, 9'd7);
    lat = 0;
    while (lat < 9) begin
      @(negedge ap_clk);
      lat++;
    end
    // This second request arrives at edge k+10 and has to be ignored.
    din0  = 32'd50;
    din1  = 9'd3;
    start = 1'b1;
    @(negedge ap_clk);
    lat++;
    start = 1'b0;
    wait_done(lat, lat);
    $display("b2b a=1000 b=7 (second 50/3 ignored) -> dout=%h rem=%h lat=%0d", dout, rem, lat);
    n_checks++;
    if (lat != 33) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d, required 33", lat);
    end
    n_checks++;
    if (dout !== 24'h00008E || rem !== 10'd6) begin
      n_fail++;
      $display("FAIL b2b_result: got dout=%h rem=%h, required 00008e 006", dout, rem);
    end
    extra_done = 0;
    repeat (45) begin
      @(negedge ap_clk);
      if (done === 1'b1) extra_done++;
    end
    n_checks++;
    if (extra_done != 0 || dout !== 24'h00008E) begin
      n_fail++;
      $display("FAIL b2b_no_queue: got %0d extra done, dout=%h, required 0 and 00008e", extra_done, dout);
    end
  endtask

  task automatic test_ce_stall;
    int lat;
    do_start(-32'sd1000, 9'd7);
    lat = 0;
    repeat (5) begin
      @(negedge ap_clk);
      lat++;
    end
    ce = 1'b0;
    repeat (5) begin
      @(negedge ap_clk);
      lat++;
    end
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: got busy=%b done=%b, required 1 0", busy, done);
    end
    ce = 1'b1;
    wait_done(lat, lat);
    $display("stall a=-1000 b=7 -> dout=%h rem=%h lat=%0d", dout, rem, lat);
    n_checks++;
    if (lat != 38) begin
      n_fail++;
      $display("FAIL stall_latency: got %0d, required 38", lat);
    end
    n_checks++;
    if (dout !== 24'hFFFF72 || rem !== 10'h3FA) begin
      n_fail++;
      $display("FAIL stall_result: got dout=%h rem=%h, required ffff72 3fa", dout, rem);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_reset_mid_calc;
    int lat;
    int stray_done;
    do_start(32'd1000, 9'd7);
    lat = 0;
    while (lat < 15) begin
      @(negedge ap_clk);
      lat++;
    end
    // Reset is asserted between clock edges. Its effect must show without a clock edge.
    ap_rst = 1'b1;
    #1;
    n_checks++;
    if ({dout, rem, busy, done, div_zero, ovf} !== 38'd0) begin
      n_fail++;
      $display("FAIL rst_async: got dout=%h rem=%h busy=%b done=%b dz=%b ovf=%b, required all 0",
               dout, rem, busy, done, div_zero, ovf);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    stray_done = 0;
    repeat (40) begin
      @(negedge ap_clk);
      if (done === 1'b1) stray_done++;
    end
    n_checks++;
    if (stray_done != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abandon: got %0d done pulses busy=%b, required 0 0", stray_done, busy);
    end
    do_start(32'd100000, 9'd511);
    wait_done(0, lat);
    $display("post-reset a=100000 b=511 -> dout=%h rem=%h lat=%0d", dout, rem, lat);
    n_checks++;
    if (lat != 33 || dout !== 24'h0000C3 || rem !== 10'd355) begin
      n_fail++;
      $display("FAIL rst_restart: got lat=%0d dout=%h rem=%h, required 33 0000c3 %h",
               lat, dout, rem, 10'd355);
    end
    @(negedge ap_clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_div_zero;
    test_overflow;
    test_back_to_back;
    test_ce_stall;
    test_reset_mid_calc;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
